// File: rtl/comparator_nbit_seq_pkg.sv
// Shared types for the sequential slice-wise magnitude comparator.
package comparator_nbit_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_e;

  // Collapse a slice compare into a single result code.
  function automatic cmp_res_e classify(input logic lt, input logic gt);
    if (gt)      return CMP_GT;
    else if (lt) return CMP_LT;
    else         return CMP_EQ;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module comparator_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt_c,
  output logic             eq_c,
  output logic             gt_c
);

  assign lt_c = (a <  b);
  assign eq_c = (a == b);
  assign gt_c = (a >  b);

endmodule

// File: rtl/comparator_nbit_seq.sv
// Multi-cycle magnitude comparator: walks operand slices MSB-first and stops
// at the first differing slice; signed mode uses offset-binary at capture.
module comparator_nbit_seq
  import comparator_nbit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [WIDTH-1:0]                   i_a,
  input  logic [WIDTH-1:0]                   i_b,
  input  logic                               i_signed,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_less,
  output logic                               o_equal,
  output logic                               o_greater,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]   o_cycles
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            less_q, less_d;
  logic            equal_q, equal_d;
  logic            greater_q, greater_d;
  logic [CW-1:0]   cycles_q, cycles_d;

  logic [CHUNK-1:0] a_sl [NCHUNK];
  logic [CHUNK-1:0] b_sl [NCHUNK];
  logic [CHUNK-1:0] a_c, b_c;
  logic             lt_c, eq_c, gt_c;
  cmp_res_e         res_c;

  // Split latched operands into slices and select the one under examination.
  always_comb begin
    for (int i = 0; i < NCHUNK; i++) begin
      a_sl[i] = a_q[i*CHUNK +: CHUNK];
      b_sl[i] = b_q[i*CHUNK +: CHUNK];
    end
    a_c = a_sl[idx_q];
    b_c = b_sl[idx_q];
  end

  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_c),
    .b    (b_c),
    .lt_c (lt_c),
    .eq_c (eq_c),
    .gt_c (gt_c)
  );

  assign res_c = classify(lt_c, gt_c);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    less_d    = less_q;
    equal_d   = equal_q;
    greater_d = greater_q;
    cycles_d  = cycles_q;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          a_d     = i_a ^ (i_signed ? MSB_MASK : '0);
          b_d     = i_b ^ (i_signed ? MSB_MASK : '0);
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        cnt_d = cnt_q + CW'(1);
        if (!eq_c || (idx_q == '0)) begin
          less_d    = (res_c == CMP_LT);
          equal_d   = (res_c == CMP_EQ);
          greater_d = (res_c == CMP_GT);
          cycles_d  = cnt_q + CW'(1);
          valid_d   = 1'b1;
          state_d   = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DONE: begin
        if (valid_q && i_ready) begin
          valid_d   = 1'b0;
          less_d    = 1'b0;
          equal_d   = 1'b0;
          greater_d = 1'b0;
          cycles_d  = '0;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      less_q    <= less_d;
      equal_q   <= equal_d;
      greater_q <= greater_d;
      cycles_q  <= cycles_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_less    = less_q;
  assign o_equal   = equal_q;
  assign o_greater = greater_q;
  assign o_cycles  = cycles_q;

endmodule

// File: tb/tb_comparator_nbit_seq.sv
// Directed bench for comparator_nbit_seq at WIDTH=16, CHUNK=4.
module tb_comparator_nbit_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned CW    = 3;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_signed;
  logic             o_valid;
  logic             i_ready;
  logic             o_less;
  logic             o_equal;
  logic             o_greater;
  logic [CW-1:0]    o_cycles;

  int total = 0;
  int bad   = 0;

  comparator_nbit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_signed  (i_signed),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_less    (o_less),
    .o_equal   (o_equal),
    .o_greater (o_greater),
    .o_cycles  (o_cycles)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Flag encodings as {less, equal, greater}.
  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  // Directed vectors: a, b, signed, expected flags, expected cycles.
  localparam int NV = 9;
  logic [15:0] va [NV] = '{16'h7000, 16'h0000, 16'h0000, 16'h1234, 16'h8000,
                           16'hFFFF, 16'h0000, 16'h1200, 16'h1230};
  logic [15:0] vb [NV] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h1235, 16'h7FFF,
                           16'hFFFF, 16'h0000, 16'h1300, 16'h1220};
  logic        vs [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  vf [NV] = '{GT, GT, LT, LT, LT, EQ, EQ, LT, GT};
  logic [2:0]  vk [NV] = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd1, 3'd4, 3'd4, 3'd2, 3'd3};

  // Wait for o_ready, hand over one operand pair, and wait for the result.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n = 0;
    while (!o_ready && n < 20) begin
      @(posedge i_clk); #1; n++;
    end
    i_a = a; i_b = b; i_signed = s; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk); #1; lat++;
    end
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_signed = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if ({o_ready, o_valid, o_less, o_equal, o_greater, o_cycles} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b flags=%b%b%b cyc=%0d want all 0",
               o_ready, o_valid, o_less, o_equal, o_greater, o_cycles);
    end
    i_rst_n = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge: got %b want 0", o_ready);
    end
    @(posedge i_clk); #1;
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_release: got %b want 1", o_ready);
    end
  endtask

  task automatic test_vectors();
    int lat;
    for (int i = 0; i < NV; i++) begin
      start_op(va[i], vb[i], vs[i]);
      total++;
      if (o_ready !== 1'b0) begin
        bad++; $display("FAIL vec%0d_ready_drop: got %b want 0", i, o_ready);
      end
      wait_result(lat);
      total++;
      if ({o_less, o_equal, o_greater} !== vf[i]) begin
        bad++;
        $display("FAIL vec%0d_flags a=%h b=%h s=%b: got %b want %b",
                 i, va[i], vb[i], vs[i], {o_less, o_equal, o_greater}, vf[i]);
      end
      total++;
      if (o_cycles !== vk[i]) begin
        bad++; $display("FAIL vec%0d_cycles: got %0d want %0d", i, o_cycles, vk[i]);
      end
      total++;
      if (lat !== int'(vk[i])) begin
        bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vk[i]);
      end
      consume();
      total++;
      if ({o_ready, o_valid, o_less, o_equal, o_greater, o_cycles} !== 8'h80) begin
        bad++;
        $display("FAIL vec%0d_after_consume: got rdy=%b vld=%b flags=%b%b%b cyc=%0d want rdy=1 rest 0",
                 i, o_ready, o_valid, o_less, o_equal, o_greater, o_cycles);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    start_op(16'h0005, 16'h0003, 1'b0);
    wait_result(lat);
    i_a = 16'h0000; i_b = 16'hFFFF; i_signed = 1'b0; i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk); #1;
      total++;
      if ({o_ready, o_valid, o_less, o_equal, o_greater, o_cycles} !== {1'b0, 1'b1, GT, 3'd4}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got rdy=%b vld=%b flags=%b%b%b cyc=%0d want rdy=0 vld=1 flags=001 cyc=4",
                 c, o_ready, o_valid, o_less, o_equal, o_greater, o_cycles);
      end
    end
    i_valid = 1'b0;
    consume();
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_no_capture: got vld=%b rdy=%b want vld=0 rdy=1", o_valid, o_ready);
    end
  endtask

  task automatic test_reset_in_cmp();
    int lat;
    start_op(16'h1234, 16'h1234, 1'b0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_ready, o_valid, o_less, o_equal, o_greater, o_cycles} !== 8'h00) begin
      bad++;
      $display("FAIL reset_in_cmp: got rdy=%b vld=%b flags=%b%b%b cyc=%0d want all 0",
               o_ready, o_valid, o_less, o_equal, o_greater, o_cycles);
    end
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_cmp_reset: got rdy=%b vld=%b want rdy=1 vld=0", o_ready, o_valid);
    end
    start_op(16'h0001, 16'h0000, 1'b0);
    wait_result(lat);
    total++;
    if ({o_less, o_equal, o_greater} !== GT || o_cycles !== 3'd4 || lat != 4) begin
      bad++;
      $display("FAIL post_reset_op: got flags=%b cyc=%0d lat=%0d want flags=001 cyc=4 lat=4",
               {o_less, o_equal, o_greater}, o_cycles, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_in_cmp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
